// File: rtl/alu_writeback.sv
// alu_writeback: execute-to-writeback stage behind the ALU.
// Evaluates the ARM condition field against the committed CPSR flags, owns the
// NZCV register, registers the register-file write behind a valid/ready
// handshake and pulses a fetch redirect whenever R15 is written.
//
// Ports:
//   i_clk, i_rst_n              clock, synchronous active-low reset
//   i_valid / o_ready           upstream handshake (o_ready is combinational)
//   i_cond, i_opcode, i_set_flags, i_rd, i_alu_result, i_alu_nzcv
//                               instruction fields and ALU outputs
//   i_flush                     squash of the writeback slot and input
//   o_cpsr_nzcv                 committed flags, fed back to the ALU
//   o_valid / i_ready           downstream handshake of the writeback slot
//   o_exec, o_wb_en, o_wb_addr, o_wb_data
//                               held instruction and register-file write
//   o_redirect, o_redirect_pc   one-cycle PC-write redirect and its target
module alu_writeback #(
   parameter logic [3:0] PC_REG     = 4'd15,
   parameter logic [3:0] RESET_NZCV = 4'b0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [3:0]  i_cond,
   input  logic [3:0]  i_opcode,
   input  logic        i_set_flags,
   input  logic [3:0]  i_rd,
   input  logic [31:0] i_alu_result,
   input  logic [3:0]  i_alu_nzcv,
   input  logic        i_flush,
   output logic [3:0]  o_cpsr_nzcv,
   output logic        o_valid,
   input  logic        i_ready,
   output logic        o_exec,
   output logic        o_wb_en,
   output logic [3:0]  o_wb_addr,
   output logic [31:0] o_wb_data,
   output logic        o_redirect,
   output logic [31:0] o_redirect_pc
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned FLAG_W = 4;

   logic              valid_q, valid_d;
   logic              exec_q, exec_d;
   logic              wb_en_q, wb_en_d;
   logic [REG_W-1:0]  wb_addr_q, wb_addr_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              redirect_q, redirect_d;
   logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
   logic [FLAG_W-1:0] nzcv_q, nzcv_d;

   logic flag_n, flag_z, flag_c, flag_v;
   logic cond_ok_c;
   logic pass_c;
   logic is_test_c;
   logic accept_c;
   logic stall_c;

   assign flag_n = nzcv_q[3];
   assign flag_z = nzcv_q[2];
   assign flag_c = nzcv_q[1];
   assign flag_v = nzcv_q[0];

   // Handshake: slot frees when empty or drained; flush blocks new input.
   assign stall_c  = valid_q & ~i_ready;
   assign o_ready  = (~valid_q | i_ready) & ~i_flush;
   assign accept_c = i_valid & o_ready;

   // TST/TEQ/CMP/CMN: flag-only opcodes, never write a register.
   assign is_test_c = (i_opcode >= 4'h8) && (i_opcode <= 4'hB);

   // Condition evaluation against the committed flags.
   always_comb begin
      cond_ok_c = 1'b0;
      case (i_cond)
         4'h0: cond_ok_c = flag_z;
         4'h1: cond_ok_c = ~flag_z;
         4'h2: cond_ok_c = flag_c;
         4'h3: cond_ok_c = ~flag_c;
         4'h4: cond_ok_c = flag_n;
         4'h5: cond_ok_c = ~flag_n;
         4'h6: cond_ok_c = flag_v;
         4'h7: cond_ok_c = ~flag_v;
         4'h8: cond_ok_c = flag_c & ~flag_z;
         4'h9: cond_ok_c = ~flag_c | flag_z;
         4'hA: cond_ok_c = (flag_n == flag_v);
         4'hB: cond_ok_c = (flag_n != flag_v);
         4'hC: cond_ok_c = ~flag_z & (flag_n == flag_v);
         4'hD: cond_ok_c = flag_z | (flag_n != flag_v);
         4'hE: cond_ok_c = 1'b1;
         default: cond_ok_c = 1'b0;
      endcase
   end

   // The instruction right behind a PC write is in the branch shadow.
   assign pass_c = cond_ok_c & ~redirect_q;

   // Next-state for the writeback slot, redirect and flags.
   always_comb begin
      valid_d       = valid_q;
      exec_d        = exec_q;
      wb_en_d       = wb_en_q;
      wb_addr_d     = wb_addr_q;
      wb_data_d     = wb_data_q;
      redirect_d    = 1'b0;
      redirect_pc_d = redirect_pc_q;
      nzcv_d        = nzcv_q;

      if (i_flush) begin
         valid_d = 1'b0;
         wb_en_d = 1'b0;
      end else if (accept_c) begin
         valid_d   = 1'b1;
         exec_d    = pass_c;
         wb_addr_d = i_rd;
         wb_data_d = i_alu_result;
         wb_en_d   = pass_c & ~is_test_c;
         if (pass_c && (i_set_flags || is_test_c)) begin
            nzcv_d = i_alu_nzcv;
         end
         if (pass_c && !is_test_c && (i_rd == PC_REG)) begin
            redirect_d    = 1'b1;
            redirect_pc_d = {i_alu_result[DATA_W-1:2], 2'b00};
         end
      end else if (!stall_c) begin
         valid_d = 1'b0;
         wb_en_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         valid_q       <= 1'b0;
         exec_q        <= 1'b0;
         wb_en_q       <= 1'b0;
         wb_addr_q     <= REG_W'(0);
         wb_data_q     <= DATA_W'(0);
         redirect_q    <= 1'b0;
         redirect_pc_q <= DATA_W'(0);
         nzcv_q        <= RESET_NZCV;
      end else begin
         valid_q       <= valid_d;
         exec_q        <= exec_d;
         wb_en_q       <= wb_en_d;
         wb_addr_q     <= wb_addr_d;
         wb_data_q     <= wb_data_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         nzcv_q        <= nzcv_d;
      end
   end

   assign o_valid       = valid_q;
   assign o_exec        = exec_q;
   assign o_wb_en       = wb_en_q;
   assign o_wb_addr     = wb_addr_q;
   assign o_wb_data     = wb_data_q;
   assign o_redirect    = redirect_q;
   assign o_redirect_pc = redirect_pc_q;
   assign o_cpsr_nzcv   = nzcv_q;

endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: self-checking bench for alu_writeback.
// Directed vector table plus a full condition/flag sweep are streamed through a
// scoreboard queue; stall, flush and reset-mid-stall are hand-written sequences.
module tb_alu_writeback;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [3:0]  i_cond;
   logic [3:0]  i_opcode;
   logic        i_set_flags;
   logic [3:0]  i_rd;
   logic [31:0] i_alu_result;
   logic [3:0]  i_alu_nzcv;
   logic        i_flush;
   logic [3:0]  o_cpsr_nzcv;
   logic        o_valid;
   logic        i_ready;
   logic        o_exec;
   logic        o_wb_en;
   logic [3:0]  o_wb_addr;
   logic [31:0] o_wb_data;
   logic        o_redirect;
   logic [31:0] o_redirect_pc;

   alu_writeback #(.PC_REG(4'd15), .RESET_NZCV(4'b0000)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_cond       (i_cond),
      .i_opcode     (i_opcode),
      .i_set_flags  (i_set_flags),
      .i_rd         (i_rd),
      .i_alu_result (i_alu_result),
      .i_alu_nzcv   (i_alu_nzcv),
      .i_flush      (i_flush),
      .o_cpsr_nzcv  (o_cpsr_nzcv),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_exec       (o_exec),
      .o_wb_en      (o_wb_en),
      .o_wb_addr    (o_wb_addr),
      .o_wb_data    (o_wb_data),
      .o_redirect   (o_redirect),
      .o_redirect_pc(o_redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  cond;
      logic [3:0]  op;
      logic        s;
      logic [3:0]  rd;
      logic [31:0] res;
      logic [3:0]  anz;
      logic        exp_exec;
      logic        exp_wb;
      logic [3:0]  exp_nzcv;
      logic        exp_redir;
      logic [31:0] exp_rpc;
   } vec_t;

   typedef struct {
      logic        exec;
      logic        wb_en;
      logic [3:0]  addr;
      logic [31:0] data;
      logic [3:0]  nzcv;
      logic        redir;
      logic [31:0] rpc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic mon_en = 1'b0;
   logic [31:0] m_rpc = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Independent reference: ARM base condition with odd codes inverting.
   function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, b;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cf;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cf & ~z;
         3'd5: b = (n == v);
         3'd6: b = ~z & (n == v);
         default: b = 1'b1;
      endcase
      return b ^ c[0];
   endfunction

   task automatic set_in(input logic [3:0] c, input logic [3:0] op, input logic s,
                         input logic [3:0] rd, input logic [31:0] res, input logic [3:0] anz);
      i_cond = c; i_opcode = op; i_set_flags = s; i_rd = rd;
      i_alu_result = res; i_alu_nzcv = anz;
   endtask

   // Present one instruction, queue its expected writeback, take one edge.
   task automatic drive(input vec_t v);
      exp_t e;
      set_in(v.cond, v.op, v.s, v.rd, v.res, v.anz);
      i_valid = 1'b1;
      if (v.exp_redir) m_rpc = v.exp_rpc;
      e.exec = v.exp_exec; e.wb_en = v.exp_wb; e.addr = v.rd; e.data = v.res;
      e.nzcv = v.exp_nzcv; e.redir = v.exp_redir; e.rpc = m_rpc;
      sb.push_back(e);
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: each valid cycle under a ready sink is a new result.
   always @(negedge clk) begin
      if (mon_en && o_valid) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("exec",    32'(o_exec),        32'(e.exec));
            chk("wb_en",   32'(o_wb_en),       32'(e.wb_en));
            chk("wb_addr", 32'(o_wb_addr),     32'(e.addr));
            chk("wb_data", o_wb_data,          e.data);
            chk("nzcv",    32'(o_cpsr_nzcv),   32'(e.nzcv));
            chk("redir",   32'(o_redirect),    32'(e.redir));
            chk("rpc",     o_redirect_pc,      e.rpc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl[15];

   initial begin
      vec_t v;
      int   waited;

      //           cond  op   s     rd     res           anz      exec  wb    nzcv     redir rpc
      tbl[0]  = '{4'hE, 4'h4, 1'b1, 4'd3,  32'h0,        4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 32'h0};
      tbl[1]  = '{4'hE, 4'hA, 1'b1, 4'd0,  32'h0,        4'b0110, 1'b1, 1'b0, 4'b0110, 1'b0, 32'h0};
      tbl[2]  = '{4'h0, 4'hD, 1'b0, 4'd1,  32'h55,       4'b1111, 1'b1, 1'b1, 4'b0110, 1'b0, 32'h0};
      tbl[3]  = '{4'h1, 4'hD, 1'b0, 4'd2,  32'h66,       4'b1111, 1'b0, 1'b0, 4'b0110, 1'b0, 32'h0};
      tbl[4]  = '{4'hE, 4'h8, 1'b0, 4'd5,  32'h0,        4'b1000, 1'b1, 1'b0, 4'b1000, 1'b0, 32'h0};
      tbl[5]  = '{4'h4, 4'hD, 1'b0, 4'd6,  32'h77,       4'b0001, 1'b1, 1'b1, 4'b1000, 1'b0, 32'h0};
      tbl[6]  = '{4'hA, 4'h2, 1'b1, 4'd7,  32'h12,       4'b0011, 1'b0, 1'b0, 4'b1000, 1'b0, 32'h0};
      tbl[7]  = '{4'hE, 4'hD, 1'b0, 4'd15, 32'h0000_1003, 4'b0000, 1'b1, 1'b1, 4'b1000, 1'b1, 32'h0000_1000};
      tbl[8]  = '{4'hE, 4'h4, 1'b1, 4'd4,  32'h9,        4'b0101, 1'b0, 1'b0, 4'b1000, 1'b0, 32'h0};
      tbl[9]  = '{4'hE, 4'hD, 1'b1, 4'd15, 32'h0000_2002, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b1, 32'h0000_2000};
      tbl[10] = '{4'hF, 4'hA, 1'b1, 4'd15, 32'h3000,     4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0};
      tbl[11] = '{4'hE, 4'h9, 1'b1, 4'd15, 32'h3004,     4'b0010, 1'b1, 1'b0, 4'b0010, 1'b0, 32'h0};
      tbl[12] = '{4'hB, 4'hD, 1'b1, 4'd8,  32'h88,       4'b1001, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h0};
      tbl[13] = '{4'h8, 4'hB, 1'b1, 4'd0,  32'h0,        4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 32'h0};
      tbl[14] = '{4'h9, 4'h4, 1'b1, 4'd9,  32'hABCD,     4'b1000, 1'b1, 1'b1, 4'b1000, 1'b0, 32'h0};

      rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      set_in(4'h0, 4'h0, 1'b0, 4'd0, 32'h0, 4'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_nzcv",   32'(o_cpsr_nzcv), 32'h0);
      chk("rst_valid",  32'(o_valid),     32'h0);
      chk("rst_ready",  32'(o_ready),     32'h1);
      chk("rst_wb_en",  32'(o_wb_en),     32'h0);
      chk("rst_redir",  32'(o_redirect),  32'h0);
      chk("rst_rpc",    o_redirect_pc,    32'h0);

      // Directed table followed by the condition sweep, all back-to-back.
      mon_en = 1'b1;
      for (int i = 0; i < 15; i++) drive(tbl[i]);
      for (int f = 0; f < 16; f++) begin
         v = '{4'hE, 4'hA, 1'b0, 4'd0, 32'h0, 4'(f), 1'b1, 1'b0, 4'(f), 1'b0, 32'h0};
         drive(v);
         for (int c = 0; c < 16; c++) begin
            v = '{4'(c), 4'hD, 1'b0, 4'd0, $urandom, 4'(~f), 1'b0, 1'b0, 4'(f), 1'b0, 32'h0};
            v.exp_exec = cond_ref(4'(c), 4'(f));
            v.exp_wb   = v.exp_exec;
            drive(v);
         end
      end
      i_valid = 1'b0;
      waited = 0;
      while (sb.size() != 0 && waited < 10) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("sb_drained", 32'(sb.size()), 32'h0);
      @(negedge clk);
      mon_en = 1'b0;
      chk("sweep_nzcv", 32'(o_cpsr_nzcv), 32'hF);

      // Stall: held slot freezes outputs and flags, blocks input.
      set_in(4'hE, 4'hD, 1'b0, 4'd10, 32'hAA, 4'b0000);
      i_valid = 1'b1; @(posedge clk); #1;
      i_ready = 1'b0;
      set_in(4'hE, 4'h4, 1'b1, 4'd11, 32'hBB, 4'b1000);
      #1 chk("stall_ready", 32'(o_ready), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("stall_valid", 32'(o_valid),     32'h1);
      chk("stall_addr",  32'(o_wb_addr),   32'd10);
      chk("stall_data",  o_wb_data,        32'hAA);
      chk("stall_nzcv",  32'(o_cpsr_nzcv), 32'hF);
      i_ready = 1'b1;
      #1 chk("unstall_ready", 32'(o_ready), 32'h1);
      @(posedge clk); #1;
      i_valid = 1'b0;
      chk("unstall_addr", 32'(o_wb_addr),   32'd11);
      chk("unstall_nzcv", 32'(o_cpsr_nzcv), 32'h8);
      chk("unstall_wb",   32'(o_wb_en),     32'h1);

      // Flush: slot cleared, incoming instruction blocked, flags untouched.
      set_in(4'hE, 4'hD, 1'b0, 4'd12, 32'hCC, 4'b0000);
      i_valid = 1'b1; @(posedge clk); #1;
      set_in(4'hE, 4'hA, 1'b1, 4'd13, 32'h0, 4'b0000);
      i_flush = 1'b1;
      #1 chk("flush_ready", 32'(o_ready), 32'h0);
      @(posedge clk); #1;
      i_flush = 1'b0; i_valid = 1'b0;
      chk("flush_valid", 32'(o_valid),     32'h0);
      chk("flush_wb",    32'(o_wb_en),     32'h0);
      chk("flush_nzcv",  32'(o_cpsr_nzcv), 32'h8);
      @(posedge clk); #1;
      chk("flush_noacc", 32'(o_valid),     32'h0);

      // PC write, then a stall: redirect still lasts one cycle; then reset mid-stall.
      set_in(4'hE, 4'hD, 1'b1, 4'd15, 32'h0000_4001, 4'b0011);
      i_valid = 1'b1; @(posedge clk); #1;
      chk("pc_redir",    32'(o_redirect),  32'h1);
      chk("pc_rpc",      o_redirect_pc,    32'h0000_4000);
      chk("pc_nzcv",     32'(o_cpsr_nzcv), 32'h3);
      i_ready = 1'b0;
      set_in(4'hE, 4'h4, 1'b1, 4'd5, 32'h5, 4'b1111);
      @(posedge clk); #1;
      chk("stall_redir0", 32'(o_redirect), 32'h0);
      chk("stall_valid2", 32'(o_valid),    32'h1);
      chk("stall_addr2",  32'(o_wb_addr),  32'd15);
      rst_n = 1'b0; i_flush = 1'b1;
      @(posedge clk); #1;
      chk("mrst_valid", 32'(o_valid),     32'h0);
      chk("mrst_exec",  32'(o_exec),      32'h0);
      chk("mrst_wb",    32'(o_wb_en),     32'h0);
      chk("mrst_addr",  32'(o_wb_addr),   32'h0);
      chk("mrst_data",  o_wb_data,        32'h0);
      chk("mrst_redir", 32'(o_redirect),  32'h0);
      chk("mrst_rpc",   o_redirect_pc,    32'h0);
      chk("mrst_nzcv",  32'(o_cpsr_nzcv), 32'h0);
      rst_n = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
      @(posedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
